// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential N-bit ALU:
//   - op encodings (OP_ADD .. OP_MUL)
//   - FSM state encoding (state_t)
//   - is_single_cycle(): tells whether an op finishes on its accept edge
//     (everything except MUL and non-zero shifts)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Shifts by zero complete immediately; MUL always iterates.
    function automatic logic is_single_cycle(input logic [2:0] op_code,
                                             input logic       shift_is_zero);
        logic single;
        case (op_code)
            OP_SHL, OP_SHR: single = shift_is_zero;
            OP_MUL:         single = 1'b0;
            default:        single = 1'b1;
        endcase
        return single;
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// -----------------------------------------------------------------------------
// alu_addsub
// Combinational WIDTH-bit adder/subtractor.
//   i_x, i_y  : operands
//   i_cin     : carry-in (add) or borrow-in (subtract)
//   i_sub     : 0 = x + y + cin, 1 = x - y - cin
//   o_sum     : WIDTH-bit result
//   o_cout    : carry-out (add) or unsigned borrow-out (subtract)
//   o_ovf     : two's-complement overflow
// Subtraction is done as x + ~y + ~cin; the raw carry of that sum is the
// inverse of the borrow, so it is flipped back on the way out.
// -----------------------------------------------------------------------------
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_y;
    logic             w_c;
    logic             w_cout_raw;

    assign w_y = i_sub ? ~i_y : i_y;
    assign w_c = i_sub ? ~i_cin : i_cin;

    assign {w_cout_raw, o_sum} = {1'b0, i_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_c};

    assign o_cout = i_sub ? ~w_cout_raw : w_cout_raw;

    // Overflow when both effective addends share a sign the sum does not.
    assign o_ovf = (i_x[WIDTH-1] == w_y[WIDTH-1]) && (o_sum[WIDTH-1] != i_x[WIDTH-1]);

endmodule

// File: rtl/alu_nbit_seq.sv
// -----------------------------------------------------------------------------
// alu_nbit_seq
// Multi-cycle N-bit ALU with start/done handshake and registered flags.
//   clk, rst          : clock, asynchronous active-high reset
//   start, op, a, b,  : request; sampled on the edge where start=1 and ready=1
//   cin
//   ready             : high in IDLE and DONE (a start is accepted there)
//   done              : one-cycle pulse, result/flags valid
//   result, cout      : registered result and carry/borrow/shift-out/MUL-high
//   zero, neg, ovf    : registered flags
// ADD..XOR and zero-length shifts complete on the accept edge. Shifts iterate
// one bit per cycle for k=b[SW-1:0] cycles. MUL runs WIDTH shift-add steps
// using the same adder instance as ADD/SUB. Outputs load only on the edge
// that enters DONE.
// -----------------------------------------------------------------------------
module alu_nbit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int SW = $clog2(WIDTH);
    // Counter must hold WIDTH for MUL, which needs one more bit than SW
    // when WIDTH is a power of two.
    localparam int CW = $clog2(WIDTH + 1);

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;       // MUL multiplicand
    logic [WIDTH-1:0] r_work;    // shift operand, or MUL low accumulator/multiplier
    logic [WIDTH-1:0] r_hi;      // MUL high accumulator
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;

    // ---------------------------------------------------------------------
    // Next-state wires
    // ---------------------------------------------------------------------
    state_t           w_state_next;
    logic [2:0]       w_op_next;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_work_next;
    logic [WIDTH-1:0] w_hi_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_load;
    logic [WIDTH-1:0] w_result_next;
    logic             w_cout_next;
    logic             w_ovf_next;

    logic [SW-1:0]    w_k;

    // ---------------------------------------------------------------------
    // Shared adder: accept-edge ADD/SUB, or MUL accumulate during EXEC
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] w_add_x;
    logic [WIDTH-1:0] w_add_y;
    logic             w_add_cin;
    logic             w_add_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_cout;
    logic             w_add_ovf;

    always_comb begin
        if (r_state == ST_EXEC) begin
            w_add_x   = r_hi;
            w_add_y   = r_a;
            w_add_cin = 1'b0;
            w_add_sub = 1'b0;
        end else begin
            w_add_x   = a;
            w_add_y   = b;
            w_add_cin = cin;
            w_add_sub = (op == OP_SUB);
        end
    end

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_x    (w_add_x),
        .i_y    (w_add_y),
        .i_cin  (w_add_cin),
        .i_sub  (w_add_sub),
        .o_sum  (w_sum),
        .o_cout (w_add_cout),
        .o_ovf  (w_add_ovf)
    );

    // ---------------------------------------------------------------------
    // Iteration datapath
    // ---------------------------------------------------------------------
    // MUL step: add multiplicand if the current multiplier LSB is set, then
    // shift the whole {carry, hi, lo} accumulator right by one.
    logic [WIDTH-1:0] w_mul_hi;
    logic             w_mul_c;
    logic [WIDTH-1:0] w_mul_hi_shift;
    logic [WIDTH-1:0] w_mul_lo_shift;

    assign w_mul_hi       = r_work[0] ? w_sum : r_hi;
    assign w_mul_c        = r_work[0] & w_add_cout;
    assign w_mul_hi_shift = {w_mul_c, w_mul_hi[WIDTH-1:1]};
    assign w_mul_lo_shift = {w_mul_hi[0], r_work[WIDTH-1:1]};

    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;

    assign w_shl = {r_work[WIDTH-2:0], 1'b0};
    assign w_shr = {1'b0, r_work[WIDTH-1:1]};

    assign w_k = b[SW-1:0];

    // ---------------------------------------------------------------------
    // Next-state / datapath control
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_op_next     = r_op;
        w_a_next      = r_a;
        w_work_next   = r_work;
        w_hi_next     = r_hi;
        w_cnt_next    = r_cnt;
        w_load        = 1'b0;
        w_result_next = r_result;
        w_cout_next   = r_cout;
        w_ovf_next    = r_ovf;

        case (r_state)
            ST_EXEC: begin
                // start is deliberately ignored here.
                w_cnt_next = r_cnt - CW'(1);
                if (r_op == OP_MUL) begin
                    w_hi_next     = w_mul_hi_shift;
                    w_work_next   = w_mul_lo_shift;
                    w_result_next = w_mul_lo_shift;
                    w_cout_next   = |w_mul_hi_shift;
                    w_ovf_next    = 1'b0;
                end else if (r_op == OP_SHL) begin
                    w_work_next   = w_shl;
                    w_result_next = w_shl;
                    w_cout_next   = r_work[WIDTH-1];
                    w_ovf_next    = 1'b0;
                end else begin
                    w_work_next   = w_shr;
                    w_result_next = w_shr;
                    w_cout_next   = r_work[0];
                    w_ovf_next    = 1'b0;
                end
                // The step taken with the counter at 1 is the last one.
                if (r_cnt <= CW'(1)) begin
                    w_load       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end

            default: begin
                // IDLE and DONE both accept a new request.
                w_state_next = ST_IDLE;
                if (start) begin
                    w_op_next = op;
                    if (is_single_cycle(op, w_k == '0)) begin
                        w_load       = 1'b1;
                        w_state_next = ST_DONE;
                        case (op)
                            OP_ADD, OP_SUB: begin
                                w_result_next = w_sum;
                                w_cout_next   = w_add_cout;
                                w_ovf_next    = w_add_ovf;
                            end
                            OP_AND: begin
                                w_result_next = a & b;
                                w_cout_next   = 1'b0;
                                w_ovf_next    = 1'b0;
                            end
                            OP_OR: begin
                                w_result_next = a | b;
                                w_cout_next   = 1'b0;
                                w_ovf_next    = 1'b0;
                            end
                            OP_XOR: begin
                                w_result_next = a ^ b;
                                w_cout_next   = 1'b0;
                                w_ovf_next    = 1'b0;
                            end
                            default: begin
                                // Zero-length shift: operand passes through.
                                w_result_next = a;
                                w_cout_next   = 1'b0;
                                w_ovf_next    = 1'b0;
                            end
                        endcase
                    end else begin
                        w_state_next = ST_EXEC;
                        if (op == OP_MUL) begin
                            w_a_next    = a;
                            w_work_next = b;
                            w_hi_next   = '0;
                            w_cnt_next  = CW'(WIDTH);
                        end else begin
                            w_work_next = a;
                            w_cnt_next  = CW'(w_k);
                        end
                    end
                end
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_work  <= '0;
            r_hi    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_op    <= w_op_next;
            r_a     <= w_a_next;
            r_work  <= w_work_next;
            r_hi    <= w_hi_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ---------------------------------------------------------------------
    // Output registers: load only on the edge entering DONE
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_load) begin
            r_result <= w_result_next;
            r_cout   <= w_cout_next;
            r_zero   <= (w_result_next == '0);
            r_neg    <= w_result_next[WIDTH-1];
            r_ovf    <= w_ovf_next;
        end
    end

    assign ready  = (r_state != ST_EXEC);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;
    assign cout   = r_cout;
    assign zero   = r_zero;
    assign neg    = r_neg;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_nbit_seq
// Self-checking bench for alu_nbit_seq at WIDTH=8: directed vectors, a
// start pulsed during EXEC, reset abort, back-to-back issue and randomized
// operations checked against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_nbit_seq;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_nbit_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .ready  (ready),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .neg    (neg),
        .ovf    (ovf)
    );

    // Reference model: plain integer arithmetic on the operation's definition.
    function automatic void ref_model(input int o, input int x, input int y, input int ci,
                                      output int r, output int co, output int ov,
                                      output int lat);
        int k;
        int sx;
        int sy;
        int t;
        k  = y % 8;
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        co = 0;
        ov = 0;
        lat = 1;
        case (o)
            0: begin
                t = x + y + ci; r = t % 256; co = t / 256;
                t = sx + sy + ci; ov = (t > 127 || t < -128) ? 1 : 0;
            end
            1: begin
                t = x - y - ci; r = (t + 512) % 256; co = (x < y + ci) ? 1 : 0;
                t = sx - sy - ci; ov = (t > 127 || t < -128) ? 1 : 0;
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: begin
                r = (x * (1 << k)) % 256;
                co = (k == 0) ? 0 : (x / (1 << (8 - k))) % 2;
                lat = k + 1;
            end
            6: begin
                r = x / (1 << k);
                co = (k == 0) ? 0 : (x / (1 << (k - 1))) % 2;
                lat = k + 1;
            end
            default: begin
                t = x * y; r = t % 256; co = (t >= 256) ? 1 : 0;
                lat = 9;
            end
        endcase
    endfunction

    // Issue one op from a point just after a clock edge, scramble inputs after
    // the accept edge, and wait (bounded) for done. Returns latency, number of
    // cycles with ready low, and a timeout flag.
    task automatic run_op(input logic [2:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                          input logic t_cin, output int lat, output int busy, output bit tmo);
        start = 1'b1; op = t_op; a = t_a; b = t_b; cin = t_cin;
        @(posedge clk); #1;
        start = 1'b0;
        op  = 3'($urandom_range(0, 7));
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
        lat = 1; busy = 0; tmo = 1'b0;
        while (done !== 1'b1) begin
            if (ready === 1'b0) busy++;
            if (lat >= 40) begin
                tmo = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({ready, done, result, cout, zero, neg, ovf} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
            n_err++;
            $display("FAIL reset_values: got rdy/done/res/c/z/n/v=%b want %b",
                     {ready, done, result, cout, zero, neg, ovf}, {1'b1, 1'b0, 8'h00, 4'b0000});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({ready, done} !== 2'b10) begin
            n_err++;
            $display("FAIL idle_after_reset: got ready/done=%b want 10", {ready, done});
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] r;
        logic       co;
        logic       z;
        logic       n;
        logic       v;
        int         lat;
        int         busy;
    } dvec_t;

    task automatic test_directed();
        dvec_t dtab[7];
        int lat;
        int busy;
        bit tmo;
        dtab[0] = '{OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
        dtab[1] = '{OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
        dtab[2] = '{OP_SUB, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0};
        dtab[3] = '{OP_SHR, 8'h05, 8'h03, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4, 3};
        dtab[4] = '{OP_SHL, 8'h81, 8'h00, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0};
        dtab[5] = '{OP_MUL, 8'h10, 8'h11, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 9, 8};
        dtab[6] = '{OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
        for (int i = 0; i < 7; i++) begin
            run_op(dtab[i].op, dtab[i].a, dtab[i].b, dtab[i].cin, lat, busy, tmo);
            $display("directed %0d: op=%0d a=%02h b=%02h cin=%0d -> res=%02h c=%0d z=%0d n=%0d v=%0d lat=%0d",
                     i, dtab[i].op, dtab[i].a, dtab[i].b, dtab[i].cin, result, cout, zero, neg, ovf, lat);
            n_vec++;
            if (tmo || lat != dtab[i].lat || busy != dtab[i].busy) begin
                n_err++;
                $display("FAIL dir%0d_latency: got lat=%0d busy=%0d tmo=%0d want lat=%0d busy=%0d",
                         i, lat, busy, tmo, dtab[i].lat, dtab[i].busy);
            end
            n_vec++;
            if ({result, cout, zero, neg, ovf} !==
                {dtab[i].r, dtab[i].co, dtab[i].z, dtab[i].n, dtab[i].v}) begin
                n_err++;
                $display("FAIL dir%0d_outputs: got res=%02h c/z/n/v=%b want res=%02h c/z/n/v=%b",
                         i, result, {cout, zero, neg, ovf},
                         dtab[i].r, {dtab[i].co, dtab[i].z, dtab[i].n, dtab[i].v});
            end
            @(posedge clk); #1;
        end
        // Result must hold with no new done while idle.
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({done, ready, result} !== {1'b0, 1'b1, 8'h30}) begin
            n_err++;
            $display("FAIL hold_after_done: got done/ready=%b res=%02h want 01 res=30",
                     {done, ready}, result);
        end
    endtask

    task automatic test_start_during_exec();
        int ndone = 0;
        int done_cyc = -1;
        logic [7:0] res_at_done = 8'h00;
        logic       c_at_done = 1'b0;
        start = 1'b1; op = OP_MUL; a = 8'h10; b = 8'h11; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (done === 1'b1) begin
                ndone++;
                done_cyc = c;
                res_at_done = result;
                c_at_done = cout;
            end
            // Competing requests while the multiply is still iterating.
            start = (c >= 2 && c <= 5);
            op = OP_ADD; a = 8'h01; b = 8'h01;
            @(posedge clk); #1;
        end
        start = 1'b0;
        $display("exec_start: MUL 10*11 done_count=%0d done_cycle=%0d res=%02h c=%0d",
                 ndone, done_cyc, res_at_done, c_at_done);
        n_vec++;
        if (ndone != 1 || done_cyc != 9) begin
            n_err++;
            $display("FAIL exec_start_done: got count=%0d cycle=%0d want count=1 cycle=9",
                     ndone, done_cyc);
        end
        n_vec++;
        if ({res_at_done, c_at_done} !== {8'h10, 1'b1}) begin
            n_err++;
            $display("FAIL exec_start_result: got res=%02h c=%0d want res=10 c=1",
                     res_at_done, c_at_done);
        end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        int lat;
        int busy;
        bit tmo;
        start = 1'b1; op = OP_MUL; a = 8'h10; b = 8'h11; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({ready, done, result, cout, zero, neg, ovf} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
            n_err++;
            $display("FAIL abort_reset_values: got rdy/done/res/c/z/n/v=%b want %b",
                     {ready, done, result, cout, zero, neg, ovf}, {1'b1, 1'b0, 8'h00, 4'b0000});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        n_vec++;
        if (ndone != 0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", ndone);
        end
        run_op(OP_AND, 8'hF0, 8'h3C, 1'b0, lat, busy, tmo);
        $display("abort_follow: AND F0 3C -> res=%02h lat=%0d", result, lat);
        n_vec++;
        if (tmo || lat != 1 || result !== 8'h30) begin
            n_err++;
            $display("FAIL abort_follow_and: got res=%02h lat=%0d tmo=%0d want res=30 lat=1",
                     result, lat, tmo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        start = 1'b1; op = OP_OR; a = 8'h0F; b = 8'hF0; cin = 1'b0;
        @(posedge clk); #1;
        $display("b2b first: OR 0F F0 -> done=%0d res=%02h n=%0d", done, result, neg);
        n_vec++;
        if ({done, result, neg, zero} !== {1'b1, 8'hFF, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_first: got done=%0d res=%02h n=%0d z=%0d want done=1 res=FF n=1 z=0",
                     done, result, neg, zero);
        end
        op = OP_XOR; a = 8'hAA; b = 8'hAA;
        @(posedge clk); #1;
        start = 1'b0;
        $display("b2b second: XOR AA AA -> done=%0d res=%02h z=%0d", done, result, zero);
        n_vec++;
        if ({done, result, zero, neg} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_second: got done=%0d res=%02h z=%0d n=%0d want done=1 res=00 z=1 n=0",
                     done, result, zero, neg);
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: got done=%0d want 0", done);
        end
    endtask

    task automatic test_random();
        int r;
        int co;
        int ov;
        int elat;
        int lat;
        int busy;
        bit tmo;
        logic [2:0] t_op;
        logic [7:0] t_a;
        logic [7:0] t_b;
        logic       t_cin;
        logic [11:0] exp_v;
        for (int i = 0; i < 60; i++) begin
            t_op  = 3'($urandom_range(0, 7));
            t_a   = 8'($urandom);
            t_b   = 8'($urandom);
            t_cin = 1'($urandom);
            ref_model(int'(t_op), int'(t_a), int'(t_b), int'(t_cin), r, co, ov, elat);
            exp_v = {r[7:0], co[0], (r[7:0] == 8'h00), r[7], ov[0]};
            run_op(t_op, t_a, t_b, t_cin, lat, busy, tmo);
            $display("rand %0d: op=%0d a=%02h b=%02h cin=%0d -> res=%02h c=%0d z=%0d n=%0d v=%0d lat=%0d",
                     i, t_op, t_a, t_b, t_cin, result, cout, zero, neg, ovf, lat);
            n_vec++;
            if ({result, cout, zero, neg, ovf} !== exp_v) begin
                n_err++;
                $display("FAIL rand%0d_outputs: got res/c/z/n/v=%b want %b",
                         i, {result, cout, zero, neg, ovf}, exp_v);
            end
            n_vec++;
            if (tmo || lat != elat) begin
                n_err++;
                $display("FAIL rand%0d_latency: got %0d (tmo=%0d) want %0d", i, lat, tmo, elat);
            end
            // Sometimes idle a cycle, otherwise issue straight from DONE.
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_during_exec();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_nbit_seq.md
# alu_nbit_seq

Parametrised, multi-cycle N-bit ALU with start/done handshake and registered status flags; the successor to the single-bit combinational ALU slice. It adds shifts and an iterative shift-add multiply to the ADD/SUB/AND/OR/XOR operations. It serves as the arithmetic engine for the datapath controller, which issues one operation at a time and waits for `done`.

## Interface
- `WIDTH`, default 8: operand/result width, must be at least 2.
- `SW`, derived as `$clog2(WIDTH)`, not overridable: shift-amount width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; accepted only when `ready`=1.
- `op` in 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- `a`, `b` in WIDTH: operands, sampled on the accept edge.
- `cin` in 1: carry-in for ADD, borrow-in for SUB, sampled on the accept edge.
- `ready` out 1: block can accept `start`.
- `done` out 1: one-cycle pulse; result and flags valid.
- `result` out WIDTH: registered result.
- `cout` out 1: carry/borrow/shifted-out/MUL-overflow.
- `zero`, `neg`, `ovf` out 1: registered flags.

## Operation
- FSM states: IDLE, EXEC, DONE. `ready`=1 in IDLE and DONE; `done`=1 only in DONE.
- Accept happens on a rising edge with `start`=1 and `ready`=1. Operands, `op` and `cin` are latched internally, so input changes after accept have no effect.
- Single-cycle ops (ADD..XOR, and SHL/SHR with k=0): computed on the accept edge, then go to DONE.
- SHL/SHR: k = `b[SW-1:0]`, giving EXEC for k cycles at one bit per cycle. The counter loads k and decrements; exit to DONE when it reaches 0.
- MUL: EXEC for WIDTH cycles of shift-add into a 2·WIDTH accumulator.
- DONE lasts one cycle, then returns to IDLE, or to the next op if `start`=1 in DONE.
- `start` while in EXEC is ignored; there is no queueing.
- ADD: {cout,result} = a+b+cin. `ovf` = signed overflow.
- SUB: result = a−b−cin modulo 2^WIDTH. `cout`=1 iff a < b+cin (unsigned borrow). `ovf` = signed overflow.
- AND/OR/XOR: bitwise. `cout`=0, `ovf`=0.
- SHL/SHR: zero-fill. `cout` = last bit shifted out, or 0 when k=0. `ovf`=0.
- MUL: unsigned. `result` = low WIDTH bits. `cout` = OR of the high WIDTH bits. `ovf`=0.
- `zero` = (result==0). `neg` = result[WIDTH-1]. Both apply to all ops.
- `result` and the flags update only on the edge entering DONE, and hold until the next DONE.
- Every `op` encoding is defined; there is no illegal-op path.

## Timing
- Latency is counted from the accept edge to the cycle in which `done`=1:
  - ADD..XOR, and shifts with k=0: 1.
  - SHL/SHR: k+1.
  - MUL: WIDTH+1.
- Back-to-back: `start` in the DONE cycle is accepted on that edge. For a single-cycle op, `done` then stays high for consecutive cycles, one pulse per op.
- Reset values: `ready`=1, `done`=0, `result`=0, `cout`=0, `zero`=0, `neg`=0, `ovf`=0. The FSM resets to IDLE and the counter to 0.
- Reset asserted mid-operation aborts immediately and asynchronously. All outputs take their reset values and no `done` is produced for the aborted op. The first edge after deassertion may accept a new `start`.

## Structure
- Package `alu_pkg` holds:
  - the op encodings as localparams (OP_ADD … OP_MUL);
  - the FSM state encoding;
  - the single-vs-multi-cycle classification function.
- One sub-module, `alu_addsub`: combinational WIDTH-bit adder/subtractor producing sum, carry/borrow and signed overflow. It is instantiated once and reused by the MUL accumulate step.
- Shift and multiply iteration, the counter, the FSM and the output registers live in `alu_nbit_seq`.

## Test plan
All scenarios use WIDTH=8.
- ADD a=0xFF, b=0x01, cin=0 -> `done` 1 cycle after accept; result=0x00, cout=1, zero=1, ovf=0.
- SUB a=0x80, b=0x01, cin=0 -> result=0x7F, cout=0, ovf=1, neg=0. SUB a=0x00, b=0x00, cin=1 -> result=0xFF, cout=1, neg=1.
- SHR a=0x05, b=3 -> `ready`=0 for 3 cycles, `done` 4 cycles after accept; result=0x00, cout=1, zero=1. SHL a=0x81, b=0 -> latency 1, result=0x81, cout=0.
- MUL a=0x10, b=0x11 -> `done` 9 cycles after accept; result=0x10, cout=1. A `start` pulsed during EXEC is ignored, and exactly one `done` is produced.
- Reset asserted 4 cycles into a MUL -> outputs take reset values at once, no `done`. A following AND a=0xF0, b=0x3C -> result=0x30.
- Back-to-back: OR a=0x0F, b=0xF0, with `start` held through DONE, then XOR a=0xAA, b=0xAA -> `done` high on two consecutive cycles. First result=0xFF with neg=1, second result=0x00 with zero=1.
